// File: rtl/tank_encoder2_f2_up_pkg.sv
// rtl/tank_encoder2_f2_up_pkg.sv - shared types and defaults for the F2-up tank-select requester
package tank_encoder2_f2_up_pkg;

   // Default digit periods per minor cycle, matching the timing chain.
   localparam int DIGITS_PER_MC_DEF = 18;
   // Default number of extra minor-cycle boundaries the address settles before strobing.
   localparam int SETTLE_MC_DEF     = 1;
   // Default digit down-counter width; must hold 2*DIGITS_PER_MC.
   localparam int CNT_W_DEF         = 6;
   // Settle counter width, covering SETTLE_MC values 0..15.
   localparam int SETTLE_W          = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // The address lines are driven in every state except IDLE.
   function automatic logic lines_driven(input state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/tank_encoder2_f2_up_dual_rail_enc.sv
// rtl/tank_encoder2_f2_up_dual_rail_enc.sv - one dual-rail select line encoder
module tank_encoder2_f2_up_dual_rail_enc (
   input  logic en,
   input  logic sel_bit,
   output logic pos,
   output logic neg
);

   // pos and neg are mutually exclusive; both low when not enabled.
   assign pos = en & sel_bit;
   assign neg = en & ~sel_bit;

endmodule

// File: rtl/tank_encoder2_f2_up.sv
// rtl/tank_encoder2_f2_up.sv - F2-up tank-select requester with minor-cycle aligned strobes
module tank_encoder2_f2_up
   import tank_encoder2_f2_up_pkg::*;
#(
   parameter int DIGITS_PER_MC = DIGITS_PER_MC_DEF,
   parameter int SETTLE_MC     = SETTLE_MC_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mc_start,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_tank,
   input  logic       req_dir,
   input  logic       req_long,
   input  logic       abort,
   output logic       done,
   output logic       aborted,
   output logic       f2_up_f7_pos,
   output logic       f2_up_f7_neg,
   output logic       f2_up_f8_pos,
   output logic       f2_up_f8_neg,
   output logic       f2_up_t_in,
   output logic       f2_up_t_out
);

   localparam logic [CNT_W-1:0]    LEN_SHORT  = CNT_W'(DIGITS_PER_MC);
   localparam logic [CNT_W-1:0]    LEN_LONG   = CNT_W'(2 * DIGITS_PER_MC);
   localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE_MC);

   state_t               state_q, state_d;
   logic [1:0]           tank_q, tank_d;
   logic                 dir_q, dir_d;
   logic                 long_q, long_d;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic [CNT_W-1:0]     dig_q, dig_d;

   logic                 ready_d, done_d, aborted_d;
   logic                 t_in_d, t_out_d, sel_en_d;
   logic                 f7_pos_d, f7_neg_d, f8_pos_d, f8_neg_d;

   // Next-state, latched request fields and registered-output next values.
   always_comb begin
      state_d   = state_q;
      tank_d    = tank_q;
      dir_d     = dir_q;
      long_d    = long_q;
      settle_d  = settle_q;
      dig_d     = dig_q;
      aborted_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d  = ST_SETUP;
               tank_d   = req_tank;
               dir_d    = req_dir;
               long_d   = req_long;
               settle_d = SETTLE_LD;
            end
         end
         ST_SETUP: begin
            // abort wins over a coincident minor-cycle boundary
            if (abort) begin
               state_d   = ST_HOLD;
               aborted_d = 1'b1;
            end else if (mc_start) begin
               if (settle_q == '0) begin
                  state_d = ST_XFER;
                  dig_d   = long_q ? LEN_LONG : LEN_SHORT;
               end else begin
                  settle_d = settle_q - 1'b1;
               end
            end
         end
         ST_XFER: begin
            // abort wins over counter expiry; the strobe drops on the same edge
            if (abort) begin
               state_d   = ST_HOLD;
               aborted_d = 1'b1;
            end else if (dig_q == CNT_W'(1)) begin
               state_d = ST_HOLD;
            end else begin
               dig_d = dig_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the state being entered, so every output is a flop.
      ready_d  = (state_d == ST_IDLE);
      done_d   = (state_d == ST_HOLD);
      t_in_d   = (state_d == ST_XFER) & dir_d;
      t_out_d  = (state_d == ST_XFER) & ~dir_d;
      sel_en_d = lines_driven(state_d);
   end

   tank_encoder2_f2_up_dual_rail_enc u_enc_f7 (
      .en      (sel_en_d),
      .sel_bit (tank_d[0]),
      .pos     (f7_pos_d),
      .neg     (f7_neg_d)
   );

   tank_encoder2_f2_up_dual_rail_enc u_enc_f8 (
      .en      (sel_en_d),
      .sel_bit (tank_d[1]),
      .pos     (f8_pos_d),
      .neg     (f8_neg_d)
   );

   // State, counters and all outputs; reset drops strobes and selects immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tank_q       <= 2'b00;
         dir_q        <= 1'b0;
         long_q       <= 1'b0;
         settle_q     <= '0;
         dig_q        <= '0;
         req_ready    <= 1'b1;
         done         <= 1'b0;
         aborted      <= 1'b0;
         f2_up_t_in   <= 1'b0;
         f2_up_t_out  <= 1'b0;
         f2_up_f7_pos <= 1'b0;
         f2_up_f7_neg <= 1'b0;
         f2_up_f8_pos <= 1'b0;
         f2_up_f8_neg <= 1'b0;
      end else begin
         state_q      <= state_d;
         tank_q       <= tank_d;
         dir_q        <= dir_d;
         long_q       <= long_d;
         settle_q     <= settle_d;
         dig_q        <= dig_d;
         req_ready    <= ready_d;
         done         <= done_d;
         aborted      <= aborted_d;
         f2_up_t_in   <= t_in_d;
         f2_up_t_out  <= t_out_d;
         f2_up_f7_pos <= f7_pos_d;
         f2_up_f7_neg <= f7_neg_d;
         f2_up_f8_pos <= f8_pos_d;
         f2_up_f8_neg <= f8_neg_d;
      end
   end

endmodule

// File: tb/tb_tank_encoder2_f2_up.sv
// tb/tb_tank_encoder2_f2_up.sv - directed self-checking bench for tank_encoder2_f2_up
module tb_tank_encoder2_f2_up;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mc_start = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_valid0 = 1'b0;
   logic [1:0] req_tank = 2'b00;
   logic       req_dir = 1'b0;
   logic       req_long = 1'b0;
   logic       abort = 1'b0;

   logic req_ready, done, aborted, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out;
   logic req_ready0, done0, aborted0, f7_pos0, f7_neg0, f8_pos0, f8_neg0, t_in0, t_out0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tank_encoder2_f2_up #(.DIGITS_PER_MC(18), .SETTLE_MC(1), .CNT_W(6)) u_dut (
      .clk(clk), .rst_n(rst_n), .mc_start(mc_start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_tank(req_tank), .req_dir(req_dir), .req_long(req_long),
      .abort(abort), .done(done), .aborted(aborted),
      .f2_up_f7_pos(f7_pos), .f2_up_f7_neg(f7_neg),
      .f2_up_f8_pos(f8_pos), .f2_up_f8_neg(f8_neg),
      .f2_up_t_in(t_in), .f2_up_t_out(t_out)
   );

   tank_encoder2_f2_up #(.DIGITS_PER_MC(18), .SETTLE_MC(0), .CNT_W(6)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mc_start(mc_start),
      .req_valid(req_valid0), .req_ready(req_ready0),
      .req_tank(req_tank), .req_dir(req_dir), .req_long(req_long),
      .abort(abort), .done(done0), .aborted(aborted0),
      .f2_up_f7_pos(f7_pos0), .f2_up_f7_neg(f7_neg0),
      .f2_up_f8_pos(f8_pos0), .f2_up_f8_neg(f8_neg0),
      .f2_up_t_in(t_in0), .f2_up_t_out(t_out0)
   );

   // Invariants checked every cycle on both instances
   always @(negedge clk) begin
      n_checks = n_checks + 1;
      if ((f7_pos & f7_neg) | (f8_pos & f8_neg) | (f7_pos0 & f7_neg0) | (f8_pos0 & f8_neg0)) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_dual_rail: f7 %b%b f8 %b%b f7_0 %b%b f8_0 %b%b, required never both", f7_pos, f7_neg, f8_pos, f8_neg, f7_pos0, f7_neg0, f8_pos0, f8_neg0);
      end
      n_checks = n_checks + 1;
      if ((t_in & t_out) | (t_in0 & t_out0)) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_one_strobe: t_in=%b t_out=%b t_in0=%b t_out0=%b, required not both", t_in, t_out, t_in0, t_out0);
      end
      n_checks = n_checks + 1;
      if (((t_in | t_out) & ~(f7_pos | f7_neg)) | ((t_in0 | t_out0) & ~(f7_pos0 | f7_neg0))) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_strobe_addr: strobe high with lines released");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic mc_pulse();
      mc_start = 1'b1;
      tick();
      mc_start = 1'b0;
   endtask

   task automatic send_req(input logic [1:0] tank, input logic dir, input logic lng);
      req_valid = 1'b1;
      req_tank  = tank;
      req_dir   = dir;
      req_long  = lng;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(2);
      n_checks++;
      if ({req_ready, done, aborted, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out} !== 9'b1_0000_0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 100000000", {req_ready, done, aborted, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out});
      end
      rst_n = 1'b1;
      idle(2);
      n_checks++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b done=%b, required 1 0", req_ready, done);
      end
   endtask

   task automatic test_short_write();
      int cnt;
      send_req(2'd2, 1'b1, 1'b0);
      n_checks++;
      if ({f7_pos, f7_neg, f8_pos, f8_neg, req_ready, t_in} !== 6'b011000) begin
         n_fail++;
         $display("FAIL t1_setup_lines: got %b, required 011000", {f7_pos, f7_neg, f8_pos, f8_neg, req_ready, t_in});
      end
      idle(3);
      mc_pulse();
      n_checks++;
      if (t_in !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_settle: t_in=%b after first mc_start, required 0", t_in);
      end
      idle(17);
      mc_pulse();
      n_checks++;
      if (t_in !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_strobe_rise: t_in=%b after second mc_start, required 1", t_in);
      end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (t_in) cnt++;
         else break;
      end
      n_checks++;
      if (cnt != 18) begin
         n_fail++;
         $display("FAIL t1_strobe_len: %0d clocks, required 18", cnt);
      end
      n_checks++;
      if ({done, aborted, f7_neg, f8_pos} !== 4'b1011) begin
         n_fail++;
         $display("FAIL t1_hold: done,aborted,f7_neg,f8_pos=%b, required 1011", {done, aborted, f7_neg, f8_pos});
      end
      tick();
      n_checks++;
      if ({done, f7_pos, f7_neg, f8_pos, f8_neg, req_ready} !== 6'b000001) begin
         n_fail++;
         $display("FAIL t1_release: got %b, required 000001", {done, f7_pos, f7_neg, f8_pos, f8_neg, req_ready});
      end
   endtask

   task automatic test_long_read();
      int  cnt;
      logic saw_in;
      send_req(2'd1, 1'b0, 1'b1);
      n_checks++;
      if ({f7_pos, f7_neg, f8_pos, f8_neg} !== 4'b1001) begin
         n_fail++;
         $display("FAIL t2_lines: got %b, required 1001", {f7_pos, f7_neg, f8_pos, f8_neg});
      end
      mc_pulse();
      idle(17);
      mc_pulse();
      cnt = t_out ? 1 : 0;
      saw_in = t_in;
      for (int i = 0; i < 100; i++) begin
         tick();
         saw_in |= t_in;
         if (t_out) cnt++;
         else break;
      end
      n_checks++;
      if (cnt != 36) begin
         n_fail++;
         $display("FAIL t2_strobe_len: %0d clocks, required 36", cnt);
      end
      n_checks++;
      if (saw_in !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_t_in: t_in seen %b, required 0", saw_in);
      end
      n_checks++;
      if (done !== 1'b1 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_done: done=%b aborted=%b, required 1 0", done, aborted);
      end
      tick();
   endtask

   task automatic test_abort();
      send_req(2'd2, 1'b1, 1'b0);
      mc_pulse();
      idle(17);
      mc_pulse();
      idle(4);
      n_checks++;
      if (t_in !== 1'b1) begin
         n_fail++;
         $display("FAIL t3_fifth_clock: t_in=%b, required 1", t_in);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({t_in, done, aborted, f7_neg, f8_pos} !== 5'b01111) begin
         n_fail++;
         $display("FAIL t3_abort_hold: t_in,done,aborted,f7_neg,f8_pos=%b, required 01111", {t_in, done, aborted, f7_neg, f8_pos});
      end
      tick();
      n_checks++;
      if ({done, aborted, req_ready, f8_pos, f7_neg} !== 5'b00100) begin
         n_fail++;
         $display("FAIL t3_idle: done,aborted,ready,f8_pos,f7_neg=%b, required 00100", {done, aborted, req_ready, f8_pos, f7_neg});
      end
   endtask

   task automatic test_back_to_back();
      logic seen;
      send_req(2'd1, 1'b1, 1'b0);
      mc_pulse();
      idle(17);
      mc_pulse();
      req_valid = 1'b1;
      req_tank  = 2'd3;
      req_dir   = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (seen !== 1'b1 || {req_ready, f7_pos, f7_neg, f8_pos, f8_neg} !== 5'b01001) begin
         n_fail++;
         $display("FAIL t4_hold_old: done_seen=%b ready,f7,f8=%b, required 1 01001", seen, {req_ready, f7_pos, f7_neg, f8_pos, f8_neg});
      end
      tick();
      n_checks++;
      if ({req_ready, f7_pos, f7_neg, f8_pos, f8_neg} !== 5'b10000) begin
         n_fail++;
         $display("FAIL t4_idle_gap: ready,f7,f8=%b, required 10000", {req_ready, f7_pos, f7_neg, f8_pos, f8_neg});
      end
      tick();
      req_valid = 1'b0;
      n_checks++;
      if ({req_ready, f7_pos, f7_neg, f8_pos, f8_neg} !== 5'b01010) begin
         n_fail++;
         $display("FAIL t4_new_accept: ready,f7,f8=%b, required 01010", {req_ready, f7_pos, f7_neg, f8_pos, f8_neg});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (done !== 1'b1 || aborted !== 1'b1) begin
         n_fail++;
         $display("FAIL t4_setup_abort: done=%b aborted=%b, required 1 1", done, aborted);
      end
      tick();
   endtask

   task automatic test_async_reset();
      logic seen;
      send_req(2'd2, 1'b0, 1'b0);
      mc_pulse();
      idle(17);
      mc_pulse();
      n_checks++;
      if (t_out !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_in_xfer: t_out=%b, required 1", t_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({t_out, f7_neg, f8_pos, done, req_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL t5_async_drop: t_out,f7_neg,f8_pos,done,ready=%b, required 00001", {t_out, f7_neg, f8_pos, done, req_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mc_pulse();
         seen |= done;
         for (int j = 0; j < 5; j++) begin
            tick();
            seen |= done;
         end
      end
      n_checks++;
      if (seen !== 1'b0 || req_ready !== 1'b1 || t_out !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_after_reset: done_seen=%b ready=%b t_out=%b, required 0 1 0", seen, req_ready, t_out);
      end
   endtask

   task automatic test_mc_on_accept();
      logic seen;
      req_valid0 = 1'b1;
      req_tank   = 2'd1;
      req_dir    = 1'b1;
      req_long   = 1'b0;
      mc_start   = 1'b1;
      tick();
      req_valid0 = 1'b0;
      mc_start   = 1'b0;
      n_checks++;
      if ({req_ready0, t_in0, f7_pos0, f8_neg0} !== 4'b0011) begin
         n_fail++;
         $display("FAIL t6_accept: ready0,t_in0,f7_pos0,f8_neg0=%b, required 0011", {req_ready0, t_in0, f7_pos0, f8_neg0});
      end
      idle(5);
      n_checks++;
      if (t_in0 !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_ignored_mc: t_in0=%b, required 0", t_in0);
      end
      mc_pulse();
      n_checks++;
      if (t_in0 !== 1'b1 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL t6_strobe: t_in0=%b other_ready=%b, required 1 1", t_in0, req_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done0) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (seen !== 1'b1 || aborted0 !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_done: done0_seen=%b aborted0=%b, required 1 0", seen, aborted0);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_short_write();
      test_long_read();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_mc_on_accept();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
